// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam int CLK_HZ      = 16_000_000;
    localparam int PERIOD_1KHZ = 16000;
    localparam int PERIOD_50HZ = 320000;  // servo rate; needs WIDTH >= 19

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered target/active duty, optional per-period
// ramp toward the target, and a registered comparator output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RAMP_STEP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             boundary,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_val,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm,
    output logic             settled
);

    localparam logic [WIDTH:0] STEP = (WIDTH+1)'(RAMP_STEP);

    logic [WIDTH-1:0] target, active, next_active;
    logic [WIDTH:0]   up_sum, dn_diff;

    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        next_active = target;
        up_sum      = {1'b0, active} + STEP;
        dn_diff     = {1'b0, active} - STEP;
        if (RAMP_STEP != 0) begin
            if (target > active)
                next_active = (up_sum > {1'b0, target}) ? target : up_sum[WIDTH-1:0];
            else if (target < active)
                next_active = (dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < target))
                              ? target : dn_diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wr)
                target <= wr_val;
            // Dropping enable zeroes active so the next run soft-starts from 0.
            if (!enable)
                active <= '0;
            else if (boundary)
                active <= next_active;
            pwm <= enable && (cnt < active);
        end
    end

    assign settled = (active == target);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared period counter, write decode with clamping to
// PERIOD, period tick, and one pwm_channel per output.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int PERIOD    = PERIOD_1KHZ,
    parameter int RAMP_STEP = 0,
    parameter int CH_W      = clog2_min1(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                duty_wr,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [WIDTH-1:0]    duty_val,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic [CHANNELS-1:0] settled
);

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(PERIOD);

    logic [WIDTH-1:0] cnt, duty_clamped;
    logic             boundary;

    assign boundary     = enable && (cnt == CNT_LAST);
    assign duty_clamped = (duty_val > DUTY_MAX) ? DUTY_MAX : duty_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            if (!enable || boundary)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            period_tick <= boundary;
        end
    end

    // Channel indices at or above CHANNELS match no instance, so such writes drop.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH    (WIDTH),
            .RAMP_STEP(RAMP_STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .enable  (enable),
            .boundary(boundary),
            .wr      (duty_wr && (duty_ch == CH_W'(i))),
            .wr_val  (duty_clamped),
            .cnt     (cnt),
            .pwm     (pwm_out[i]),
            .settled (settled[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: one instance without ramp (d0) and one with
// RAMP_STEP=2 (d2), both PERIOD=10, four channels.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int P  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          d0_en, d0_wr, d2_en, d2_wr;
    logic [2:0]    d0_ch, d2_ch;
    logic [W-1:0]  d0_val, d2_val;
    logic [CH-1:0] d0_pwm, d0_stl, d2_pwm, d2_stl;
    logic          d0_tick, d2_tick;

    pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .RAMP_STEP(0), .CH_W(3)) d0 (
        .clk(clk), .rst_n(rst_n), .enable(d0_en), .duty_wr(d0_wr), .duty_ch(d0_ch),
        .duty_val(d0_val), .pwm_out(d0_pwm), .period_tick(d0_tick), .settled(d0_stl));

    pwm_multi #(.CHANNELS(CH), .WIDTH(W), .PERIOD(P), .RAMP_STEP(2), .CH_W(3)) d2 (
        .clk(clk), .rst_n(rst_n), .enable(d2_en), .duty_wr(d2_wr), .duty_ch(d2_ch),
        .duty_val(d2_val), .pwm_out(d2_pwm), .period_tick(d2_tick), .settled(d2_stl));

    int errors = 0;
    int checks = 0;

    logic [P-1:0]  wave [CH];
    logic [P-1:0]  tickv;
    logic [CH-1:0] stl;

    // Expected one-period waveform: high for the first d counter values.
    function automatic logic [P-1:0] ones(input int d);
        logic [P:0] v;
        v = (P+1)'(1) << d;
        return P'(v - (P+1)'(1));
    endfunction

    // Records the next P negedge samples (one full period); write strobes end here.
    task automatic capture(input int sel);
        for (int k = 0; k < P; k++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++)
                wave[c][k] = (sel == 1) ? d2_pwm[c] : d0_pwm[c];
            tickv[k] = (sel == 1) ? d2_tick : d0_tick;
            if (k == 0) stl = (sel == 1) ? d2_stl : d0_stl;
            d0_wr = 1'b0;
            d2_wr = 1'b0;
        end
    endtask

    task automatic wait_tick(input int sel);
        int  n;
        logic t;
        n = 0;
        do begin
            @(negedge clk);
            d0_wr = 1'b0;
            d2_wr = 1'b0;
            n++;
            t = (sel == 1) ? d2_tick : d0_tick;
        end while (!t && n < 50);
        checks++;
        if (!t) begin
            errors++;
            $display("FAIL wait_tick_d%0d: period_tick=0 after %0d cycles, expected 1", sel, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; d0_en = 1'b0; d2_en = 1'b0; d0_wr = 1'b0; d2_wr = 1'b0;
        d0_ch = '0; d2_ch = '0; d0_val = '0; d2_val = '0;
        #12;
        checks++; if (d0_pwm !== 4'h0) begin errors++; $display("FAIL reset_d0_pwm: got %h expected 0", d0_pwm); end
        checks++; if (d0_tick !== 1'b0) begin errors++; $display("FAIL reset_d0_tick: got %b expected 0", d0_tick); end
        checks++; if (d0_stl !== 4'hF) begin errors++; $display("FAIL reset_d0_settled: got %h expected f", d0_stl); end
        checks++; if (d2_pwm !== 4'h0) begin errors++; $display("FAIL reset_d2_pwm: got %h expected 0", d2_pwm); end
        checks++; if (d2_stl !== 4'hF) begin errors++; $display("FAIL reset_d2_settled: got %h expected f", d2_stl); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        rst_n = 1'b1; d0_en = 1'b1; d2_en = 1'b1;
        d0_wr = 1'b1; d0_ch = 3'd0; d0_val = 8'd3;
        capture(0);
        checks++; if (wave[0] !== '0) begin errors++; $display("FAIL first_period_ch0: got %b expected 0", wave[0]); end
        checks++; if (tickv !== 10'h200) begin errors++; $display("FAIL first_period_tick: got %b expected %b", tickv, 10'h200); end
        for (int r = 0; r < 2; r++) begin
            capture(0);
            checks++; if (wave[0] !== ones(3)) begin errors++; $display("FAIL duty3_period%0d: got %b expected %b", r, wave[0], ones(3)); end
            checks++; if (tickv !== 10'h200) begin errors++; $display("FAIL tick_spacing%0d: got %b expected %b", r, tickv, 10'h200); end
        end
    endtask

    task automatic test_boundary_values();
        int exp_d [CH] = '{3, 0, 10, 10};
        d0_wr = 1'b1; d0_ch = 3'd1; d0_val = 8'd0;
        @(negedge clk); d0_ch = 3'd2; d0_val = 8'd10;
        @(negedge clk); d0_ch = 3'd3; d0_val = 8'd50;
        @(negedge clk); d0_wr = 1'b0;
        wait_tick(0);
        capture(0);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (wave[c] !== ones(exp_d[c])) begin
                errors++; $display("FAIL bound_ch%0d: got %b expected %b", c, wave[c], ones(exp_d[c]));
            end
        end
        checks++; if (stl !== 4'hF) begin errors++; $display("FAIL bound_settled: got %h expected f", stl); end
    endtask

    task automatic test_write_at_boundary();
        repeat (P - 1) @(negedge clk);
        d0_wr = 1'b1; d0_ch = 3'd0; d0_val = 8'd5;
        @(negedge clk);
        d0_wr = 1'b0;
        checks++; if (d0_tick !== 1'b1) begin errors++; $display("FAIL wr_at_boundary_tick: got %b expected 1", d0_tick); end
        capture(0);
        checks++; if (wave[0] !== ones(3)) begin errors++; $display("FAIL wr_boundary_old: got %b expected %b", wave[0], ones(3)); end
        capture(0);
        checks++; if (wave[0] !== ones(5)) begin errors++; $display("FAIL wr_boundary_new: got %b expected %b", wave[0], ones(5)); end
    endtask

    task automatic test_ramp();
        int e0 [5] = '{2, 4, 6, 7, 7};
        int s0 [5] = '{0, 0, 0, 1, 1};
        int e1 [5] = '{2, 4, 6, 8, 10};
        int s1 [5] = '{0, 0, 0, 0, 1};
        int f0 [4] = '{7, 5, 3, 1};
        int g0 [4] = '{0, 0, 0, 1};
        wait_tick(1);
        d2_wr = 1'b1; d2_ch = 3'd0; d2_val = 8'd7;
        @(negedge clk); d2_ch = 3'd1; d2_val = 8'd50;
        @(negedge clk); d2_wr = 1'b0;
        wait_tick(1);
        for (int p = 0; p < 5; p++) begin
            capture(1);
            checks++; if (wave[0] !== ones(e0[p])) begin errors++; $display("FAIL ramp_up_ch0_p%0d: got %b expected %b", p, wave[0], ones(e0[p])); end
            checks++; if (stl[0] !== 1'(s0[p])) begin errors++; $display("FAIL ramp_up_settled0_p%0d: got %b expected %0d", p, stl[0], s0[p]); end
            checks++; if (wave[1] !== ones(e1[p])) begin errors++; $display("FAIL ramp_clamp_ch1_p%0d: got %b expected %b", p, wave[1], ones(e1[p])); end
            checks++; if (stl[1] !== 1'(s1[p])) begin errors++; $display("FAIL ramp_clamp_settled1_p%0d: got %b expected %0d", p, stl[1], s1[p]); end
        end
        d2_wr = 1'b1; d2_ch = 3'd0; d2_val = 8'd1;
        for (int p = 0; p < 4; p++) begin
            capture(1);
            checks++; if (wave[0] !== ones(f0[p])) begin errors++; $display("FAIL ramp_down_ch0_p%0d: got %b expected %b", p, wave[0], ones(f0[p])); end
            checks++; if (stl[0] !== 1'(g0[p])) begin errors++; $display("FAIL ramp_down_settled0_p%0d: got %b expected %0d", p, stl[0], g0[p]); end
        end
    endtask

    task automatic test_enable_drop();
        int e0 [4] = '{1, 3, 5, 6};
        int r0 [3] = '{2, 4, 6};
        int s0 [3] = '{0, 0, 1};
        d2_wr = 1'b1; d2_ch = 3'd0; d2_val = 8'd6;
        for (int p = 0; p < 4; p++) begin
            capture(1);
            checks++; if (wave[0] !== ones(e0[p])) begin errors++; $display("FAIL to6_ch0_p%0d: got %b expected %b", p, wave[0], ones(e0[p])); end
        end
        repeat (3) @(negedge clk);
        checks++; if (d2_pwm[0] !== 1'b1) begin errors++; $display("FAIL pre_disable_pwm0: got %b expected 1", d2_pwm[0]); end
        d2_en = 1'b0;
        @(negedge clk);
        checks++; if (d2_pwm !== 4'h0) begin errors++; $display("FAIL disable_pwm: got %h expected 0", d2_pwm); end
        checks++; if (d2_tick !== 1'b0) begin errors++; $display("FAIL disable_tick: got %b expected 0", d2_tick); end
        checks++; if (d2_stl[0] !== 1'b0) begin errors++; $display("FAIL disable_target_kept: settled0 got %b expected 0", d2_stl[0]); end
        repeat (3) @(negedge clk);
        d2_en = 1'b1;
        capture(1);
        checks++; if (wave[0] !== '0) begin errors++; $display("FAIL reenable_first_ch0: got %b expected 0", wave[0]); end
        checks++; if (tickv !== 10'h200) begin errors++; $display("FAIL reenable_tick: got %b expected %b", tickv, 10'h200); end
        for (int p = 0; p < 3; p++) begin
            capture(1);
            checks++; if (wave[0] !== ones(r0[p])) begin errors++; $display("FAIL soft_start_ch0_p%0d: got %b expected %b", p, wave[0], ones(r0[p])); end
            checks++; if (stl[0] !== 1'(s0[p])) begin errors++; $display("FAIL soft_start_settled0_p%0d: got %b expected %0d", p, stl[0], s0[p]); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        checks++; if (d0_pwm[2] !== 1'b1) begin errors++; $display("FAIL pre_reset_pwm2: got %b expected 1", d0_pwm[2]); end
        rst_n = 1'b0;
        #1;
        checks++; if (d0_pwm !== 4'h0) begin errors++; $display("FAIL async_d0_pwm: got %h expected 0", d0_pwm); end
        checks++; if (d0_tick !== 1'b0) begin errors++; $display("FAIL async_d0_tick: got %b expected 0", d0_tick); end
        checks++; if (d0_stl !== 4'hF) begin errors++; $display("FAIL async_d0_settled: got %h expected f", d0_stl); end
        checks++; if (d2_pwm !== 4'h0) begin errors++; $display("FAIL async_d2_pwm: got %h expected 0", d2_pwm); end
        checks++; if (d2_stl !== 4'hF) begin errors++; $display("FAIL async_d2_settled: got %h expected f", d2_stl); end
        @(negedge clk);
        rst_n = 1'b1;
        d0_wr = 1'b1; d0_ch = 3'd4; d0_val = 8'd5;
        capture(0);
        checks++; if (stl !== 4'hF) begin errors++; $display("FAIL bad_ch_settled: got %h expected f", stl); end
        checks++; if (tickv !== 10'h200) begin errors++; $display("FAIL post_reset_tick: got %b expected %b", tickv, 10'h200); end
        capture(0);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if (wave[c] !== '0) begin
                errors++; $display("FAIL bad_ch_ignored_ch%0d: got %b expected 0", c, wave[c]);
            end
        end
        checks++; if (stl !== 4'hF) begin errors++; $display("FAIL bad_ch_settled_after: got %h expected f", stl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary_values();
        test_write_at_boundary();
        test_ramp();
        test_enable_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
